reg_tree_param: RTL and testbench

REG_TREE_PARAM -- requirements
Module: reg_tree_param

---
 rtl/reg_tree_pkg.sv | 59 +++++
 rtl/reg_tree_node.sv | 45 ++++
 rtl/reg_tree_param.sv | 86 ++++++++
 tb/tb_reg_tree_param.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_tree_pkg.sv
// -----------------------------------------------------------------------------
// reg_tree_pkg
// Purpose : Shared sizing helpers for the replicated-register fanout tree.
//           level_size() returns how many registers sit on a given tree level,
//           min_depth() returns the smallest legal depth for a NUM_OUT/FANOUT
//           pair when the root is a single register.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package reg_tree_pkg;

  localparam int MIN_FANOUT = 32'sd2;

  // Ceiling division; a zero divisor returns the dividend so that an illegal
  // FANOUT cannot crash elaboration before the parameter check reports it.
  function automatic int ceil_div(input int a, input int b);
    if (b <= 32'sd0) begin
      return a;
    end else begin
      return (a + b - 32'sd1) / b;
    end
  endfunction

  // Registers on tree level 'level'. The leaf level (depth-1) holds num_out
  // registers; each level above holds enough parents to drive the level below
  // with at most 'fanout' children each, never fewer than one.
  function automatic int level_size(input int num_out, input int fanout,
                                    input int depth, input int level);
    int n;
    n = num_out;
    for (int j = depth - 32'sd1; j > level; j--) begin
      n = ceil_div(n, fanout);
      if (n < 32'sd1) begin
        n = 32'sd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Smallest depth whose root level collapses to a single register:
  // 1 + ceil(log_fanout(num_out)). Loop is bounded for degenerate fanout.
  function automatic int min_depth(input int num_out, input int fanout);
    int n;
    int d;
    n = num_out;
    d = 32'sd1;
    for (int i = 0; i < 32; i++) begin
      if (n > 32'sd1) begin
        n = ceil_div(n, fanout);
        d = d + 32'sd1;
      end else begin
        n = n;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/reg_tree_node.sv
// -----------------------------------------------------------------------------
// reg_tree_node
// Purpose : One tree register: a data word plus its valid bit, advanced when
//           i_en is high, held otherwise, cleared asynchronously by rst_n.
// Ports   : clk      - clock
//           rst_n    - asynchronous active-low reset
//           i_en     - stage enable (0 = hold)
//           i_valid  - valid bit from the parent
//           i_data   - data word from the parent
//           o_valid  - registered valid
//           o_data   - registered data
// -----------------------------------------------------------------------------
module reg_tree_node #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // Data and valid stage register; data loads regardless of valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= {DATA_WIDTH{1'b0}};
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end else begin
      r_valid <= r_valid;
      r_data  <= r_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/reg_tree_param.sv
// -----------------------------------------------------------------------------
// reg_tree_param
// Purpose : Replicates one input word onto NUM_OUT outputs through a DEPTH-level
//           register tree whose registers each drive at most FANOUT children.
//           Every output sees exactly DEPTH enabled cycles of latency.
// Ports   : clk       - clock
//           rst_n     - asynchronous active-low reset
//           en        - stage enable for the whole tree (0 = hold)
//           in_valid  - qualifier for in
//           in        - word to replicate
//           out       - packed outputs, output k = out[k*DATA_WIDTH +: DATA_WIDTH]
//           out_valid - bit k qualifies output k
// -----------------------------------------------------------------------------
module reg_tree_param
  import reg_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_OUT    = 7,
  parameter int DEPTH      = 5,
  parameter int FANOUT     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out,
  output logic [NUM_OUT-1:0]            out_valid
);

  localparam int MIN_D = min_depth(NUM_OUT, FANOUT);

  // DEPTH=1 is the explicit direct-load case: the level-0 fanout limit is
  // waived, so the depth bound only applies to deeper trees.
  if ((NUM_OUT < 1) || (FANOUT < MIN_FANOUT) || (DEPTH < 1) ||
      ((DEPTH > 1) && (NUM_OUT > 1) && (DEPTH < MIN_D))) begin : g_param_err
    $error("reg_tree_param: illegal NUM_OUT/FANOUT/DEPTH combination");
  end

  // Tree storage indexed [level][register]. Levels above the leaf are narrower
  // than NUM_OUT; their unused slots are tied to zero and never read.
  logic [DATA_WIDTH-1:0] w_data  [DEPTH][NUM_OUT];
  logic                  w_valid [DEPTH][NUM_OUT];

  for (genvar j = 0; j < DEPTH; j++) begin : g_lvl
    localparam int LSIZE = level_size(NUM_OUT, FANOUT, DEPTH, j);

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
      if (i < LSIZE) begin : g_node
        logic [DATA_WIDTH-1:0] w_d_in;
        logic                  w_v_in;

        if (j == 0) begin : g_root
          assign w_d_in = in;
          assign w_v_in = in_valid;
        end else begin : g_child
          // Register i is fed by parent floor(i/FANOUT) one level up.
          assign w_d_in = w_data[j-1][i/FANOUT];
          assign w_v_in = w_valid[j-1][i/FANOUT];
        end

        reg_tree_node #(
          .DATA_WIDTH (DATA_WIDTH)
        ) u_node (
          .clk     (clk),
          .rst_n   (rst_n),
          .i_en    (en),
          .i_valid (w_v_in),
          .i_data  (w_d_in),
          .o_valid (w_valid[j][i]),
          .o_data  (w_data[j][i])
        );
      end else begin : g_unused
        assign w_data[j][i]  = {DATA_WIDTH{1'b0}};
        assign w_valid[j][i] = 1'b0;
      end
    end
  end

  // Outputs come straight from the leaf registers.
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out[k*DATA_WIDTH +: DATA_WIDTH] = w_data[DEPTH-1][k];
    assign out_valid[k]                    = w_valid[DEPTH-1][k];
  end

endmodule

// File: tb/tb_reg_tree_param.sv
module tb_reg_tree_param;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [15:0] tb_in;

  logic [7*16-1:0]  out7;
  logic [6:0]       ov7;
  logic [16*16-1:0] out16;
  logic [15:0]      ov16;
  logic [3*16-1:0]  out3;
  logic [2:0]       ov3;

  int n_cmp = 0;
  int n_bad = 0;

  reg_tree_param u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(tb_in),
    .out(out7), .out_valid(ov7)
  );

  reg_tree_param #(.DATA_WIDTH(16), .NUM_OUT(16), .DEPTH(5), .FANOUT(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(tb_in),
    .out(out16), .out_valid(ov16)
  );

  reg_tree_param #(.DATA_WIDTH(16), .NUM_OUT(3), .DEPTH(1), .FANOUT(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(tb_in),
    .out(out3), .out_valid(ov3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {data, valid} images with the word replicated on every output.
  function automatic logic [7*16+6:0] e7(input logic [15:0] d, input logic v);
    return {{7{d}}, {7{v}}};
  endfunction
  function automatic logic [16*16+15:0] e16(input logic [15:0] d, input logic v);
    return {{16{d}}, {16{v}}};
  endfunction
  function automatic logic [3*16+2:0] e3(input logic [15:0] d, input logic v);
    return {{3{d}}, {3{v}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; tb_in = 16'hFFFF;
    tick(); tick();
    n_cmp++;
    if ({out7, ov7} !== e7(16'h0, 1'b0)) begin
      n_bad++; $display("FAIL reset_d7 got %h want %h", {out7, ov7}, e7(16'h0, 1'b0));
    end
    n_cmp++;
    if ({out16, ov16} !== e16(16'h0, 1'b0)) begin
      n_bad++; $display("FAIL reset_d16 got %h want %h", {out16, ov16}, e16(16'h0, 1'b0));
    end
    n_cmp++;
    if ({out3, ov3} !== e3(16'h0, 1'b0)) begin
      n_bad++; $display("FAIL reset_d3 got %h want %h", {out3, ov3}, e3(16'h0, 1'b0));
    end
    in_valid = 1'b0; tb_in = 16'h0;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_single();
    logic [7*16+6:0]   x7;
    logic [16*16+15:0] x16;
    logic [3*16+2:0]   x3;
    tb_in = 16'h1234; in_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      tb_in = 16'h0; in_valid = 1'b0;
      x7  = (k == 5) ? e7(16'h1234, 1'b1)  : e7(16'h0, 1'b0);
      x16 = (k == 5) ? e16(16'h1234, 1'b1) : e16(16'h0, 1'b0);
      x3  = (k == 1) ? e3(16'h1234, 1'b1)  : e3(16'h0, 1'b0);
      n_cmp++;
      if ({out7, ov7} !== x7) begin
        n_bad++; $display("FAIL single_d7 k=%0d got %h want %h", k, {out7, ov7}, x7);
      end
      n_cmp++;
      if ({out16, ov16} !== x16) begin
        n_bad++; $display("FAIL single_d16 k=%0d got %h want %h", k, {out16, ov16}, x16);
      end
      n_cmp++;
      if ({out3, ov3} !== x3) begin
        n_bad++; $display("FAIL single_d3 k=%0d got %h want %h", k, {out3, ov3}, x3);
      end
    end
  endtask

  task automatic test_stream();
    logic [15:0] d5;
    logic        v5;
    for (int m = 1; m <= 100; m++) begin
      tb_in = 16'(m - 1); in_valid = 1'b1;
      tick();
      d5 = (m >= 5) ? 16'(m - 5) : 16'h0;
      v5 = (m >= 5);
      n_cmp++;
      if ({out7, ov7} !== e7(d5, v5)) begin
        n_bad++; $display("FAIL stream_d7 m=%0d got %h want %h", m, {out7, ov7}, e7(d5, v5));
      end
      n_cmp++;
      if ({out16, ov16} !== e16(d5, v5)) begin
        n_bad++; $display("FAIL stream_d16 m=%0d got %h want %h", m, {out16, ov16}, e16(d5, v5));
      end
      n_cmp++;
      if ({out3, ov3} !== e3(16'(m - 1), 1'b1)) begin
        n_bad++; $display("FAIL stream_d3 m=%0d got %h want %h", m, {out3, ov3}, e3(16'(m - 1), 1'b1));
      end
    end
    tb_in = 16'h0; in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_stall();
    logic [7*16+6:0]   x7;
    logic [16*16+15:0] x16;
    logic [3*16+2:0]   x3;
    tb_in = 16'hA5A5; in_valid = 1'b1; en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tb_in = 16'h0; in_valid = 1'b0;
      en = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;  // edges 2..4 held
      x7  = (k == 8) ? e7(16'hA5A5, 1'b1)  : e7(16'h0, 1'b0);
      x16 = (k == 8) ? e16(16'hA5A5, 1'b1) : e16(16'h0, 1'b0);
      x3  = (k <= 4) ? e3(16'hA5A5, 1'b1)  : e3(16'h0, 1'b0);
      n_cmp++;
      if ({out7, ov7} !== x7) begin
        n_bad++; $display("FAIL stall_d7 k=%0d got %h want %h", k, {out7, ov7}, x7);
      end
      n_cmp++;
      if ({out16, ov16} !== x16) begin
        n_bad++; $display("FAIL stall_d16 k=%0d got %h want %h", k, {out16, ov16}, x16);
      end
      n_cmp++;
      if ({out3, ov3} !== x3) begin
        n_bad++; $display("FAIL stall_d3 k=%0d got %h want %h", k, {out3, ov3}, x3);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [7*16+6:0]   x7;
    logic [16*16+15:0] x16;
    logic [3*16+2:0]   x3;
    for (int m = 1; m <= 7; m++) begin
      tb_in = 16'h0100 + 16'(m); in_valid = 1'b1;
      tick();
    end
    n_cmp++;
    if ({out7, ov7} !== e7(16'h0103, 1'b1)) begin
      n_bad++; $display("FAIL prerst_d7 got %h want %h", {out7, ov7}, e7(16'h0103, 1'b1));
    end
    n_cmp++;
    if ({out3, ov3} !== e3(16'h0107, 1'b1)) begin
      n_bad++; $display("FAIL prerst_d3 got %h want %h", {out3, ov3}, e3(16'h0107, 1'b1));
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out7, ov7} !== e7(16'h0, 1'b0)) begin
      n_bad++; $display("FAIL asyncrst_d7 got %h want %h", {out7, ov7}, e7(16'h0, 1'b0));
    end
    n_cmp++;
    if ({out16, ov16} !== e16(16'h0, 1'b0)) begin
      n_bad++; $display("FAIL asyncrst_d16 got %h want %h", {out16, ov16}, e16(16'h0, 1'b0));
    end
    n_cmp++;
    if ({out3, ov3} !== e3(16'h0, 1'b0)) begin
      n_bad++; $display("FAIL asyncrst_d3 got %h want %h", {out3, ov3}, e3(16'h0, 1'b0));
    end
    tb_in = 16'h01FF;
    tick();
    n_cmp++;
    if ({out7, ov7} !== e7(16'h0, 1'b0)) begin
      n_bad++; $display("FAIL inrst_d7 got %h want %h", {out7, ov7}, e7(16'h0, 1'b0));
    end
    tb_in = 16'h0; in_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_cmp++;
      if ({out7, ov7} !== e7(16'h0, 1'b0)) begin
        n_bad++; $display("FAIL postrst_d7 k=%0d got %h want %h", k, {out7, ov7}, e7(16'h0, 1'b0));
      end
      n_cmp++;
      if ({out16, ov16} !== e16(16'h0, 1'b0)) begin
        n_bad++; $display("FAIL postrst_d16 k=%0d got %h want %h", k, {out16, ov16}, e16(16'h0, 1'b0));
      end
    end
    tb_in = 16'hBEEF; in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tb_in = 16'h0; in_valid = 1'b0;
      x7  = (k == 5) ? e7(16'hBEEF, 1'b1)  : e7(16'h0, 1'b0);
      x16 = (k == 5) ? e16(16'hBEEF, 1'b1) : e16(16'h0, 1'b0);
      x3  = (k == 1) ? e3(16'hBEEF, 1'b1)  : e3(16'h0, 1'b0);
      n_cmp++;
      if ({out7, ov7} !== x7) begin
        n_bad++; $display("FAIL resume_d7 k=%0d got %h want %h", k, {out7, ov7}, x7);
      end
      n_cmp++;
      if ({out16, ov16} !== x16) begin
        n_bad++; $display("FAIL resume_d16 k=%0d got %h want %h", k, {out16, ov16}, x16);
      end
      n_cmp++;
      if ({out3, ov3} !== x3) begin
        n_bad++; $display("FAIL resume_d3 k=%0d got %h want %h", k, {out3, ov3}, x3);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_stall();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
